divider: RTL and testbench

//  Iterative unsigned restoring divider; inverse of the multiplier in the arithmetic library.

---
 rtl/arith_pkg.sv | 20 ++
 rtl/div_step.sv | 23 ++
 rtl/divider.sv | 138 +++++++++++++
 tb/tb_divider.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the iterative arithmetic blocks (multiplier and divider):
// handshake FSM encoding plus iteration/counter sizing helpers.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } arith_state_t;

    function automatic int iter_count(input int width, input int frac);
        return width + frac;
    endfunction

    // Counter must be able to hold ITER itself, not just ITER-1.
    function automatic int count_width(input int iter);
        return $clog2(iter + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int C_WIDTH = 32
) (
    input  logic [C_WIDTH:0]   rem_cur,
    input  logic               d_bit,
    input  logic [C_WIDTH-1:0] divisor,
    output logic [C_WIDTH:0]   rem_next,
    output logic               q_bit
);

    logic [C_WIDTH:0] shifted;
    logic [C_WIDTH:0] diff;

    always_comb begin
        shifted  = {rem_cur[C_WIDTH-1:0], d_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = (shifted >= {1'b0, divisor});
        rem_next = q_bit ? diff : shifted;
    end

endmodule

// File: rtl/divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, with the
// same trigger/ready/done handshake as the multiplier.
module divider
    import arith_pkg::*;
#(
    parameter int C_WIDTH     = 32,
    parameter int FIXED_POINT = 0
) (
    input  logic               ctl_clk,
    input  logic               reset,
    input  logic [C_WIDTH-1:0] a,
    input  logic [C_WIDTH-1:0] b,
    input  logic               trigger,
    output logic [C_WIDTH-1:0] y,
    output logic [C_WIDTH-1:0] r,
    output logic               ready,
    output logic               done,
    output logic               div_zero,
    output logic               overflow
);

    localparam int ITER = iter_count(C_WIDTH, FIXED_POINT);
    localparam int CW   = count_width(ITER);
    localparam logic [CW-1:0] ITER_CNT = CW'(ITER);

    arith_state_t state;
    arith_state_t next_state;

    logic [ITER-1:0]    dividend;
    logic [ITER-1:0]    quotient;
    logic [ITER-1:0]    q_high;
    logic [C_WIDTH:0]   partial;
    logic [C_WIDTH:0]   step_rem;
    logic [C_WIDTH-1:0] divisor;
    logic [CW-1:0]      count;
    logic               zero_div;
    logic               step_q;
    logic               accept;
    logic               quot_ovf;

    div_step #(
        .C_WIDTH(C_WIDTH)
    ) u_step (
        .rem_cur (partial),
        .d_bit   (dividend[ITER-1]),
        .divisor (divisor),
        .rem_next(step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge ctl_clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = (state != ST_CALC);
        accept     = trigger && ready;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = (b == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (count == CW'(1)) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    next_state = (b == '0) ? ST_DONE : ST_CALC;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Quotient bits above C_WIDTH can only be set when fraction bits widen the dividend.
    always_comb begin
        q_high   = quotient >> C_WIDTH;
        quot_ovf = |q_high;
    end

    always_ff @(posedge ctl_clk) begin
        if (reset) begin
            dividend <= '0;
            quotient <= '0;
            partial  <= '0;
            divisor  <= '0;
            count    <= '0;
            zero_div <= 1'b0;
            y        <= '0;
            r        <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            // Results publish on the DONE edge; a same-edge accept reloads the
            // working registers without disturbing the values read here.
            if (state == ST_DONE) begin
                done <= 1'b1;
                if (zero_div) begin
                    y        <= '1;
                    r        <= dividend[ITER-1:FIXED_POINT];
                    div_zero <= 1'b1;
                    overflow <= 1'b0;
                end else begin
                    y        <= quot_ovf ? '1 : quotient[C_WIDTH-1:0];
                    r        <= partial[C_WIDTH-1:0];
                    div_zero <= 1'b0;
                    overflow <= quot_ovf;
                end
            end
            if (accept) begin
                dividend <= ITER'(a) << FIXED_POINT;
                divisor  <= b;
                zero_div <= (b == '0);
                partial  <= '0;
                quotient <= '0;
                count    <= ITER_CNT;
            end else if (state == ST_CALC) begin
                partial  <= step_rem;
                dividend <= dividend << 1;
                quotient <= {quotient[ITER-2:0], step_q};
                count    <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed and randomized checks of the divider against an arithmetic model,
// one integer instance (FIXED_POINT=0) and one Q16.16 instance (FIXED_POINT=16).
module tb_divider;

    logic        clk;
    logic        reset;
    logic [31:0] a0, b0, a1, b1;
    logic        trig0, trig1;
    logic [31:0] y0, r0, y1, r1;
    logic        ready0, done0, dz0, ov0;
    logic        ready1, done1, dz1, ov1;

    int checks;
    int failures;

    divider #(.C_WIDTH(32), .FIXED_POINT(0)) dut_int (
        .ctl_clk(clk), .reset(reset), .a(a0), .b(b0), .trigger(trig0),
        .y(y0), .r(r0), .ready(ready0), .done(done0),
        .div_zero(dz0), .overflow(ov0)
    );

    divider #(.C_WIDTH(32), .FIXED_POINT(16)) dut_fix (
        .ctl_clk(clk), .reset(reset), .a(a1), .b(b1), .trigger(trig1),
        .y(y1), .r(r1), .ready(ready1), .done(done1),
        .div_zero(dz1), .overflow(ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] out_y(input int sel);
        return (sel == 0) ? y0 : y1;
    endfunction

    function automatic logic [31:0] out_r(input int sel);
        return (sel == 0) ? r0 : r1;
    endfunction

    function automatic logic out_done(input int sel);
        return (sel == 0) ? done0 : done1;
    endfunction

    function automatic logic out_ready(input int sel);
        return (sel == 0) ? ready0 : ready1;
    endfunction

    function automatic logic out_dz(input int sel);
        return (sel == 0) ? dz0 : dz1;
    endfunction

    function automatic logic out_ov(input int sel);
        return (sel == 0) ? ov0 : ov1;
    endfunction

    function automatic int frac_bits(input int sel);
        return (sel == 0) ? 0 : 16;
    endfunction

    // Reference: plain wide integer division of the scaled dividend.
    function automatic void model(input logic [31:0] op_a, input logic [31:0] op_b,
                                  input int fp, output logic [31:0] ey,
                                  output logic [31:0] er, output logic edz,
                                  output logic eov);
        logic [63:0] num;
        logic [63:0] q;
        logic [63:0] rem;
        num = {32'h0, op_a} << fp;
        if (op_b == 32'h0) begin
            ey  = 32'hFFFF_FFFF;
            er  = op_a;
            edz = 1'b1;
            eov = 1'b0;
        end else begin
            q   = num / {32'h0, op_b};
            rem = num % {32'h0, op_b};
            eov = (q > 64'h0000_0000_FFFF_FFFF);
            ey  = eov ? 32'hFFFF_FFFF : q[31:0];
            er  = rem[31:0];
            edz = 1'b0;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input logic [31:0] op_a,
                                 input logic [31:0] op_b, input logic trig);
        if (sel == 0) begin
            a0 = op_a; b0 = op_b; trig0 = trig;
        end else begin
            a1 = op_a; b1 = op_b; trig1 = trig;
        end
    endtask

    // Counts edges after the accept edge until done is seen (bounded).
    task automatic waitDone(input int sel, output int lat);
        lat = 0;
        do begin
            stepClk();
            lat++;
        end while (!out_done(sel) && lat < 200);
    endtask

    task automatic checkResult(input int sel, input string tag,
                               input logic [31:0] op_a, input logic [31:0] op_b);
        logic [31:0] ey, er;
        logic        edz, eov;
        model(op_a, op_b, frac_bits(sel), ey, er, edz, eov);
        checkOutput({tag, " y"}, 64'(out_y(sel)), 64'(ey));
        checkOutput({tag, " r"}, 64'(out_r(sel)), 64'(er));
        checkOutput({tag, " div_zero"}, 64'(out_dz(sel)), 64'(edz));
        checkOutput({tag, " overflow"}, 64'(out_ov(sel)), 64'(eov));
    endtask

    task automatic runOp(input int sel, input logic [31:0] op_a,
                         input logic [31:0] op_b, input string tag);
        int lat;
        int exp_lat;
        logic [31:0] held_y;
        exp_lat = (op_b == 32'h0) ? 1 : 32 + frac_bits(sel) + 1;
        checkOutput({tag, " ready"}, 64'(out_ready(sel)), 64'd1);
        applyStimulus(sel, op_a, op_b, 1'b1);
        stepClk();
        applyStimulus(sel, $urandom, $urandom, 1'b0);
        waitDone(sel, lat);
        checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
        checkResult(sel, tag, op_a, op_b);
        held_y = out_y(sel);
        stepClk();
        checkOutput({tag, " done_drop"}, 64'(out_done(sel)), 64'd0);
        checkOutput({tag, " y_hold"}, 64'(out_y(sel)), 64'(held_y));
    endtask

    initial begin
        int lat;
        int pulses;
        logic [31:0] ra, rb, rc, rd;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        applyStimulus(0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1, 32'h0, 32'h0, 1'b0);
        repeat (3) stepClk();

        checkOutput("reset ready", 64'(ready0), 64'd1);
        checkOutput("reset done", 64'(done0), 64'd0);
        checkOutput("reset y", 64'(y0), 64'd0);
        checkOutput("reset r", 64'(r0), 64'd0);
        checkOutput("reset div_zero", 64'(dz0), 64'd0);
        checkOutput("reset overflow", 64'(ov1), 64'd0);
        reset = 1'b0;
        stepClk();

        $display("[TB] directed integer cases");
        runOp(0, 32'hEE6C_3250, 32'h1BCA_53C2, "int_basic");
        checkOutput("int_basic spec_y", 64'(y0), 64'h0000_0008);
        checkOutput("int_basic spec_r", 64'(r0), 64'h1019_9440);

        runOp(0, 32'h1234_5678, 32'h0, "int_divzero");
        checkOutput("int_divzero spec_y", 64'(y0), 64'hFFFF_FFFF);
        checkOutput("int_divzero spec_r", 64'(r0), 64'h1234_5678);

        // Back-to-back: trigger held so the second op is accepted on the DONE edge.
        ra = $urandom;
        rb = $urandom >> $urandom_range(0, 20);
        if (rb == 32'h0) rb = 32'h3;
        applyStimulus(0, ra, rb, 1'b1);
        stepClk();
        applyStimulus(0, 32'hFEDC_BA98, 32'h1234_5678, 1'b1);
        waitDone(0, lat);
        checkOutput("b2b first latency", 64'(lat), 64'd33);
        checkResult(0, "b2b first", ra, rb);
        applyStimulus(0, $urandom, $urandom, 1'b0);
        stepClk();
        checkOutput("b2b done_drop", 64'(done0), 64'd0);
        lat = 1;
        while (!done0 && lat < 200) begin
            stepClk();
            lat++;
        end
        checkOutput("b2b second latency", 64'(lat), 64'd33);
        checkOutput("b2b second y", 64'(y0), 64'h0000_000E);
        checkOutput("b2b second r", 64'(r0), 64'h0000_0008);
        stepClk();

        $display("[TB] directed fixed-point cases");
        runOp(1, 32'h7FFF_0000, 32'h0000_0001, "fix_ovf");
        checkOutput("fix_ovf spec_y", 64'(y1), 64'hFFFF_FFFF);
        checkOutput("fix_ovf spec_flag", 64'(ov1), 64'd1);
        runOp(1, 32'h0003_0000, 32'h0002_0000, "fix_1p5");
        checkOutput("fix_1p5 spec_y", 64'(y1), 64'h0001_8000);
        checkOutput("fix_1p5 spec_flag", 64'(ov1), 64'd0);

        $display("[TB] reset during calculation");
        applyStimulus(0, $urandom, 32'h0000_1235, 1'b1);
        stepClk();
        applyStimulus(0, $urandom, $urandom, 1'b0);
        repeat (9) stepClk();
        reset = 1'b1;
        stepClk();
        reset = 1'b0;
        checkOutput("abort ready", 64'(ready0), 64'd1);
        checkOutput("abort y", 64'(y0), 64'd0);
        checkOutput("abort r", 64'(r0), 64'd0);
        checkOutput("abort done", 64'(done0), 64'd0);
        pulses = 0;
        repeat (40) begin
            stepClk();
            if (done0) pulses++;
        end
        checkOutput("abort no_done", 64'(pulses), 64'd0);

        // A trigger pulse in the middle of CALC must not disturb the running op.
        ra = $urandom;
        rb = $urandom >> 8;
        if (rb == 32'h0) rb = 32'h7;
        rc = $urandom;
        rd = $urandom >> 12;
        if (rd == 32'h0) rd = 32'h5;
        applyStimulus(0, ra, rb, 1'b1);
        stepClk();
        applyStimulus(0, rc, rd, 1'b0);
        lat = 0;
        do begin
            stepClk();
            lat++;
            if (lat == 10) trig0 = 1'b1;
            else if (lat == 11) trig0 = 1'b0;
        end while (!done0 && lat < 200);
        checkOutput("busy_ignore latency", 64'(lat), 64'd33);
        checkResult(0, "busy_ignore", ra, rb);
        stepClk();
        runOp(0, rc, rd, "after_busy");

        $display("[TB] randomized cases");
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i == 5) rb = 32'h0;
            runOp(0, ra, rb, $sformatf("rand_int%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i == 3) rb = 32'h0;
            runOp(1, ra, rb, $sformatf("rand_fix%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
